keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner_if.sv | 22 ++
 rtl/keypad_scanner.sv | 249 ++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// Keypad matrix lines plus the debounced key-event outputs that feed the letter FSM.
// The scanner uses the master view; the keypad/consumer side uses the slave view.
interface keypad_scanner_if;
  logic [3:0] columns;
  logic [3:0] rows;
  logic       strobe;
  logic [7:0] cur_key;

  modport master (
    input  columns,
    output rows,
    output strobe,
    output cur_key
  );

  modport slave (
    output columns,
    input  rows,
    input  strobe,
    input  cur_key
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: drives rows, samples synchronized columns once per row dwell,
// classifies each full sweep and debounces press/release into a single strobe per press.
module keypad_scanner #(
  parameter int SCAN_CYCLES    = 100,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             nRst,
  keypad_scanner_if.master kp
);

  localparam int DW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] DEB_TARGET = CW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } sweep_res_t;

  // Pressed-column count of one row sample, saturated at 2 (any multi-column row is a multi-press).
  function automatic logic [1:0] col_count(input logic [3:0] cols);
    logic [2:0] ones;
    ones = 3'd0;
    for (int i = 0; i < 4; i++) begin
      ones = ones + {2'b00, cols[i]};
    end
    if (ones > 3'd1) begin
      col_count = 2'd2;
    end else begin
      col_count = ones[1:0];
    end
  endfunction

  logic [3:0]    col_meta_r;
  logic [3:0]    col_sync_r;
  logic [DW-1:0] dwell_r;
  logic [1:0]    row_idx_r;
  logic [3:0]    rows_r;
  logic [1:0]    sweep_n_r;
  logic [7:0]    sweep_key_r;
  state_t        state_r;
  logic [CW-1:0] deb_cnt_r;
  logic [7:0]    cand_r;
  logic [7:0]    cur_key_r;
  logic          strobe_r;

  logic          sample_s;
  logic          eval_s;
  logic [1:0]    row_cnt_s;
  logic [2:0]    n_sum_s;
  logic [1:0]    n_tot_s;
  logic [7:0]    key_tot_s;
  sweep_res_t    res_s;
  state_t        state_nxt_s;
  logic [CW-1:0] cnt_nxt_s;
  logic [CW-1:0] cnt_inc_s;
  logic [7:0]    cand_nxt_s;
  logic          accept_s;

  assign sample_s  = (dwell_r == DWELL_LAST);
  assign eval_s    = sample_s && (row_idx_r == 2'd3);
  assign row_cnt_s = col_count(col_sync_r);
  assign n_sum_s   = {1'b0, sweep_n_r} + {1'b0, row_cnt_s};
  assign cnt_inc_s = deb_cnt_r + CW'(1);

  // Two-flop synchronizer for the asynchronous keypad columns.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      col_meta_r <= 4'd0;
      col_sync_r <= 4'd0;
    end else begin
      col_meta_r <= kp.columns;
      col_sync_r <= col_meta_r;
    end
  end

  // Row dwell counter and one-hot row drive; scanning never pauses.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      dwell_r   <= {DW{1'b0}};
      row_idx_r <= 2'd0;
      rows_r    <= 4'b1000;
    end else if (sample_s) begin
      dwell_r   <= {DW{1'b0}};
      row_idx_r <= row_idx_r + 2'd1;
      rows_r    <= {rows_r[0], rows_r[3:1]};
    end else begin
      dwell_r   <= dwell_r + DW'(1);
    end
  end

  // Sweep totals including the row being sampled this cycle.
  always_comb begin
    n_tot_s   = sweep_n_r;
    key_tot_s = sweep_key_r;
    if (sample_s) begin
      if (n_sum_s >= 3'd2) begin
        n_tot_s = 2'd2;
      end else begin
        n_tot_s = n_sum_s[1:0];
      end
      if (row_cnt_s == 2'd1) begin
        key_tot_s = {rows_r, col_sync_r};
      end else begin
        key_tot_s = sweep_key_r;
      end
    end else begin
      n_tot_s   = sweep_n_r;
      key_tot_s = sweep_key_r;
    end
  end

  // Sweep classification, only meaningful on the R3 sample cycle.
  always_comb begin
    res_s = RES_NONE;
    case (n_tot_s)
      2'd0:    res_s = RES_NONE;
      2'd1:    res_s = RES_SINGLE;
      default: res_s = RES_MULTI;
    endcase
  end

  // Per-sweep accumulators; cleared once the sweep has been evaluated.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sweep_n_r   <= 2'd0;
      sweep_key_r <= 8'd0;
    end else if (eval_s) begin
      sweep_n_r   <= 2'd0;
      sweep_key_r <= 8'd0;
    end else if (sample_s) begin
      sweep_n_r   <= n_tot_s;
      sweep_key_r <= key_tot_s;
    end
  end

  // Press/release debounce state machine; advances only when a sweep is evaluated.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = deb_cnt_r;
    cand_nxt_s  = cand_r;
    accept_s    = 1'b0;
    if (eval_s) begin
      case (state_r)
        SCAN: begin
          if (res_s == RES_SINGLE) begin
            cand_nxt_s = key_tot_s;
            if (DEBOUNCE_SCANS == 1) begin
              accept_s    = 1'b1;
              cnt_nxt_s   = {CW{1'b0}};
              state_nxt_s = PRESSED;
            end else begin
              cnt_nxt_s   = CW'(1);
              state_nxt_s = DEBOUNCE;
            end
          end else begin
            cnt_nxt_s   = {CW{1'b0}};
            state_nxt_s = SCAN;
          end
        end
        DEBOUNCE: begin
          if ((res_s == RES_SINGLE) && (key_tot_s == cand_r)) begin
            if (cnt_inc_s >= DEB_TARGET) begin
              accept_s    = 1'b1;
              cnt_nxt_s   = {CW{1'b0}};
              state_nxt_s = PRESSED;
            end else begin
              cnt_nxt_s   = cnt_inc_s;
            end
          end else if (res_s == RES_SINGLE) begin
            cand_nxt_s = key_tot_s;
            cnt_nxt_s  = CW'(1);
          end else begin
            cnt_nxt_s   = {CW{1'b0}};
            state_nxt_s = SCAN;
          end
        end
        PRESSED: begin
          if (res_s == RES_NONE) begin
            if (DEBOUNCE_SCANS == 1) begin
              cnt_nxt_s   = {CW{1'b0}};
              state_nxt_s = SCAN;
            end else begin
              cnt_nxt_s   = CW'(1);
              state_nxt_s = RELEASE;
            end
          end else begin
            cnt_nxt_s   = {CW{1'b0}};
            state_nxt_s = PRESSED;
          end
        end
        RELEASE: begin
          if (res_s == RES_NONE) begin
            if (cnt_inc_s >= DEB_TARGET) begin
              cnt_nxt_s   = {CW{1'b0}};
              state_nxt_s = SCAN;
            end else begin
              cnt_nxt_s   = cnt_inc_s;
            end
          end else begin
            cnt_nxt_s   = {CW{1'b0}};
            state_nxt_s = PRESSED;
          end
        end
        default: begin
          cnt_nxt_s   = {CW{1'b0}};
          state_nxt_s = SCAN;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
      cnt_nxt_s   = deb_cnt_r;
    end
  end

  // FSM state plus the registered strobe/cur_key outputs.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_r   <= SCAN;
      deb_cnt_r <= {CW{1'b0}};
      cand_r    <= 8'd0;
      cur_key_r <= 8'd0;
      strobe_r  <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      deb_cnt_r <= cnt_nxt_s;
      cand_r    <= cand_nxt_s;
      strobe_r  <= accept_s;
      if (accept_s) begin
        cur_key_r <= key_tot_s;
      end
    end
  end

  assign kp.rows    = rows_r;
  assign kp.strobe  = strobe_r;
  assign kp.cur_key = cur_key_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model drives the columns, and a sweep-level
// reference model predicts rows, strobe and cur_key every cycle; tables and sequences add targeted checks.
module tb_keypad_scanner;
  localparam int SC    = 4;
  localparam int DEB   = 2;
  localparam int SWEEP = 4 * SC;

  logic clk  = 1'b0;
  logic nRst = 1'b0;

  keypad_scanner_if kp ();

  keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_SCANS(DEB)) dut (
    .clk  (clk),
    .nRst (nRst),
    .kp   (kp)
  );

  always #5 clk = ~clk;

  // Pressed keys: key_mat[row] holds column bits, bit3 = C0.
  logic [3:0] key_mat [4];
  logic [3:0] col_drive;

  always_comb begin
    col_drive = 4'd0;
    for (int r = 0; r < 4; r++) begin
      if (kp.rows[3-r]) col_drive = col_drive | key_mat[r];
    end
    kp.columns = col_drive;
  end

  int n_checks   = 0;
  int n_fail     = 0;
  int strobe_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] km(input int r, input int c);
    logic [15:0] v;
    v = 16'd0;
    v[15 - 4*r - c] = 1'b1;
    return v;
  endfunction

  task automatic set_keys(input logic [15:0] m);
    for (int r = 0; r < 4; r++) key_mat[r] = m[15 - 4*r -: 4];
  endtask

  // ---------------- reference model (per-edge, sweep-level rules) ----------------
  int          m_e = 0, m_n = 0, m_run = 0, m_none = 0, m_strobes = 0, m_r = 0;
  bit          m_pressed = 1'b0, exp_strobe = 1'b0;
  logic [7:0]  m_key = 8'd0, m_run_key = 8'd0, exp_key = 8'd0;
  logic [15:0] m_d1 = 16'd0, m_d2 = 16'd0;
  logic [3:0]  m_cb = 4'd0;
  logic [3:0]  exp_rows;

  initial begin : ref_model
    forever begin
      @(posedge clk or negedge nRst);
      exp_strobe = 1'b0;
      if (!nRst) begin
        m_e = 0; m_n = 0; m_run = 0; m_none = 0; m_strobes = 0;
        m_pressed = 1'b0; exp_key = 8'd0; m_key = 8'd0; m_run_key = 8'd0;
        m_d1 = 16'd0; m_d2 = 16'd0;
      end else begin
        if (m_e % SC == SC - 1) begin
          m_r  = (m_e / SC) % 4;
          m_cb = m_d2[15 - 4*m_r -: 4];      // columns seen two edges ago
          if ($countones(m_cb) == 1) begin
            m_n++;
            m_key = {4'b1000 >> m_r, m_cb};
          end else if ($countones(m_cb) > 1) begin
            m_n += 2;
          end
          if (m_r == 3) begin
            if (!m_pressed) begin
              if (m_n == 1) begin
                if (m_run > 0 && m_run_key == m_key) m_run++;
                else begin m_run = 1; m_run_key = m_key; end
              end else m_run = 0;
              if (m_run >= DEB) begin
                exp_strobe = 1'b1; exp_key = m_key; m_pressed = 1'b1;
                m_run = 0; m_none = 0; m_strobes++;
              end
            end else begin
              if (m_n == 0) m_none++; else m_none = 0;
              if (m_none >= DEB) begin m_pressed = 1'b0; m_none = 0; end
            end
            m_n = 0;
          end
        end
        m_d2 = m_d1;
        m_d1 = {key_mat[0], key_mat[1], key_mat[2], key_mat[3]};
        m_e++;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial begin : cycle_checker
    @(negedge clk);
    forever begin
      @(negedge clk);
      exp_rows = 4'b1000 >> ((m_e / SC) % 4);
      check("rows",    32'(kp.rows),    32'(exp_rows));
      check("strobe",  32'(kp.strobe),  32'(exp_strobe));
      check("cur_key", 32'(kp.cur_key), 32'(exp_key));
      if (kp.strobe === 1'b1) strobe_cnt++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns on the negedge where reset is released; the next posedge is scan cycle 0.
  task automatic do_reset(input logic [15:0] m);
    @(negedge clk);
    #2 nRst = 1'b0;
    set_keys(m);
    repeat (3) @(negedge clk);
    nRst = 1'b1;
    strobe_cnt = 0;
  endtask

  typedef struct {
    int         row;
    int         col;
    int         hold;
    int         exp_strobes;
    logic [7:0] exp_key;
  } vec_t;

  vec_t vecs [6];

  initial begin : stimulus
    set_keys(16'd0);
    vecs[0] = '{1, 2, 12*SWEEP, 1, 8'b0100_0010};
    vecs[1] = '{0, 0, 40,       1, 8'b1000_1000};
    vecs[2] = '{3, 0, 40,       1, 8'b0001_1000};
    vecs[3] = '{2, 3, 40,       1, 8'b0010_0001};
    vecs[4] = '{3, 3, 40,       1, 8'b0001_0001};
    vecs[5] = '{0, 1, 10,       0, 8'b0000_0000};
    cycles(4);

    // Single presses held from reset release, then released.
    for (int i = 0; i < 6; i++) begin
      do_reset(km(vecs[i].row, vecs[i].col));
      cycles(vecs[i].hold);
      set_keys(16'd0);
      cycles(3 * SWEEP);
      check("vec_strobes", 32'(strobe_cnt), 32'(vecs[i].exp_strobes));
      check("vec_key",     32'(kp.cur_key), 32'(vecs[i].exp_key));
    end

    // Bounce on R3C0: alternating every 10 cycles for 5 sweeps, then stable.
    do_reset(16'd0);
    cycles(11);
    for (int c = 0; c < 5 * SWEEP; c++) begin
      set_keys(((c % 20) < 10) ? km(3, 0) : 16'd0);
      @(negedge clk);
    end
    check("bounce_quiet", 32'(strobe_cnt), 32'd0);
    set_keys(km(3, 0));
    cycles(40);
    check("bounce_strobes", 32'(strobe_cnt), 32'd1);
    check("bounce_key",     32'(kp.cur_key), 32'h18);

    // Re-press R2C0 after a full release, then a too-short release.
    do_reset(km(2, 0));
    cycles(48);
    set_keys(16'd0);
    cycles(40);
    set_keys(km(2, 0));
    cycles(48);
    check("repress_strobes", 32'(strobe_cnt), 32'd2);
    check("repress_key",     32'(kp.cur_key), 32'h28);
    set_keys(16'd0);
    cycles(SWEEP);
    set_keys(km(2, 0));
    cycles(48);
    check("short_release", 32'(strobe_cnt), 32'd2);

    // Two keys together, then one released.
    do_reset(km(0, 0) | km(2, 2));
    cycles(48);
    check("multi_quiet", 32'(strobe_cnt), 32'd0);
    check("multi_key",   32'(kp.cur_key), 32'h00);
    set_keys(km(0, 0));
    cycles(48);
    check("multi_then_single", 32'(strobe_cnt), 32'd1);
    check("multi_single_key",  32'(kp.cur_key), 32'h88);

    // Reset while debouncing R2C3, key still held through reset.
    do_reset(km(2, 3));
    cycles(20);
    #2 nRst = 1'b0;
    @(negedge clk);
    check("rst_rows",    32'(kp.rows),    32'h8);
    check("rst_strobe",  32'(kp.strobe),  32'h0);
    check("rst_cur_key", 32'(kp.cur_key), 32'h00);
    cycles(2);
    nRst = 1'b1;
    check("rst_quiet", 32'(strobe_cnt), 32'd0);
    strobe_cnt = 0;
    cycles(40);
    check("rst_repress_strobes", 32'(strobe_cnt), 32'd1);
    check("rst_repress_key",     32'(kp.cur_key), 32'h21);

    // Random key activity checked against the model every cycle.
    do_reset(16'd0);
    for (int i = 0; i < 40; i++) begin
      int mode;
      mode = int'($urandom_range(0, 9));
      if (mode < 2) begin
        set_keys(16'd0);
      end else if (mode < 8) begin
        set_keys(km(int'($urandom_range(0, 3)), int'($urandom_range(0, 3))));
      end else begin
        set_keys(km(int'($urandom_range(0, 3)), int'($urandom_range(0, 3))) |
                 km(int'($urandom_range(0, 3)), int'($urandom_range(0, 3))));
      end
      cycles(int'($urandom_range(4, 60)));
    end
    set_keys(16'd0);
    cycles(3 * SWEEP);
    check("random_strobe_count", 32'(strobe_cnt), 32'(m_strobes));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
